// File: rtl/wport_arbiter_if.sv
// Register-file write-port arbitration bundle.
// lock exists only when WARB_LOCK_EN is defined.
interface wport_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int AW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
`ifdef WARB_LOCK_EN
    logic [NREQ-1:0]    lock;
`endif
    logic [NREQ-1:0]    gnt;
    logic               rf_we;
    logic [AW-1:0]      rf_addr;
    logic [DW-1:0]      rf_data;
    logic               busy;

    modport master (
        output req, req_addr, req_data,
`ifdef WARB_LOCK_EN
        output lock,
`endif
        input  gnt, rf_we, rf_addr, rf_data, busy
    );

    modport slave (
        input  req, req_addr, req_data,
`ifdef WARB_LOCK_EN
        input  lock,
`endif
        output gnt, rf_we, rf_addr, rf_data, busy
    );
endinterface

// File: rtl/wport_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// Optional ownership lock enabled by defining WARB_LOCK_EN.
module wport_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int AW   = 4
) (
    input  logic CLK,
    input  logic RST,
    wport_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ARB, LOCKED} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [AW-1:0]   addr_a [NREQ];
    logic [DW-1:0]   data_a [NREQ];
    logic [NREQ-1:0] elig;
    logic            hit;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    int              idx;
    logic            keep;
    logic            win_lock;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = bus.req_addr[i*AW +: AW];
            data_a[i] = bus.req_data[i*DW +: DW];
        end
    end

    // A port that was just granted sits out one round.
    assign elig = bus.req & ~gnt_q;

    always_comb begin
        hit  = 1'b0;
        win  = ptr_q;
        idx  = 0;
        cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = PW'(idx);
            if (!hit && elig[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
    end

`ifdef WARB_LOCK_EN
    assign keep     = (state_q == LOCKED) && bus.req[ptr_q]
                      && bus.lock[ptr_q];
    assign win_lock = bus.lock[win];
`else
    assign keep     = 1'b0;
    assign win_lock = 1'b0;
`endif

    always_comb begin
        state_d = ARB;
        gnt_d   = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (keep) begin
            // Owner keeps the port every cycle, no mask.
            state_d       = LOCKED;
            gnt_d[ptr_q]  = 1'b1;
            we_d          = 1'b1;
            addr_d        = addr_a[ptr_q];
            data_d        = data_a[ptr_q];
        end else if (hit) begin
            state_d    = win_lock ? LOCKED : ARB;
            gnt_d[win] = 1'b1;
            we_d       = 1'b1;
            addr_d     = addr_a[win];
            data_d     = data_a[win];
            ptr_d      = win;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ARB;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ptr_q   <= PW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.rf_we   = we_q;
    assign bus.rf_addr = addr_q;
    assign bus.rf_data = data_q;
    assign bus.busy    = |(bus.req & ~gnt_q);
endmodule

// File: tb/tb_wport_arbiter.sv
// Scoreboard bench for wport_arbiter (NREQ=4).
// Lock scenario runs only when WARB_LOCK_EN is defined.
module tb_wport_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    typedef struct packed {
        logic [3:0]  g;
        logic        we;
        logic [3:0]  a;
        logic [15:0] d;
        logic        b;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  pa [4];
    logic [15:0] pd [4];
    logic [3:0]  last_a = '0;
    logic [15:0] last_d = '0;
`ifdef WARB_LOCK_EN
    logic [3:0]  lk = '0;
`endif

    wport_arbiter_if #(.NREQ(4), .DW(16), .AW(4)) bus ();

    wport_arbiter #(.NREQ(4), .DW(16), .AW(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests; w is the index expected to win, -1 for none.
    task automatic cyc(input logic [3:0] r, input int w);
        exp_t e;
        @(negedge clk);
        bus.req = r;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*4 +: 4]   = pa[i];
            bus.req_data[i*16 +: 16] = pd[i];
        end
`ifdef WARB_LOCK_EN
        bus.lock = lk;
`endif
        if (w < 0) begin
            e.g  = '0;
            e.we = 1'b0;
            e.a  = last_a;
            e.d  = last_d;
        end else begin
            e.g    = 4'(1 << w);
            e.we   = 1'b1;
            e.a    = pa[w];
            e.d    = pd[w];
            last_a = pa[w];
            last_d = pd[w];
        end
        e.b = |(r & ~e.g);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt",  32'(bus.gnt),     32'(e.g));
        chk("we",   32'(bus.rf_we),   32'(e.we));
        chk("addr", 32'(bus.rf_addr), 32'(e.a));
        chk("data", 32'(bus.rf_data), 32'(e.d));
        chk("busy", 32'(bus.busy),    32'(e.b));
    endtask

    initial begin
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
`ifdef WARB_LOCK_EN
        bus.lock     = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            pa[i] = 4'(i + 4);
            pd[i] = 16'hC000 + 16'(i);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",  32'(bus.gnt),     32'h0);
        chk("rst_we",   32'(bus.rf_we),   32'h0);
        chk("rst_addr", 32'(bus.rf_addr), 32'h0);
        chk("rst_data", 32'(bus.rf_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) cyc(4'hF, k % 4);
        cyc(4'h0, -1);

        pa[0] = 4'd3;
        pd[0] = 16'hBEEF;
        cyc(4'h1, 0);
        cyc(4'h0, -1);

        for (int k = 0; k < 5; k++) cyc(4'h4, (k % 2 == 0) ? 2 : -1);
        cyc(4'h0, -1);

        cyc(4'h5, 0);
        cyc(4'h4, 2);
        cyc(4'h0, -1);

        cyc(4'hF, 3);
        #2 rst = 1'b1;
        #1;
        chk("mid_gnt",  32'(bus.gnt),     32'h0);
        chk("mid_we",   32'(bus.rf_we),   32'h0);
        chk("mid_addr", 32'(bus.rf_addr), 32'h0);
        chk("mid_data", 32'(bus.rf_data), 32'h0);
        rst    = 1'b0;
        last_a = '0;
        last_d = '0;
        cyc(4'hF, 0);
        cyc(4'hF, 1);
        cyc(4'h0, -1);

`ifdef WARB_LOCK_EN
        lk = 4'b0001;
        cyc(4'h3, 0);
        cyc(4'h3, 0);
        cyc(4'h3, 0);
        lk = 4'b0000;
        cyc(4'h3, 1);
        cyc(4'h0, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
